// File: rtl/rtc_bus_cycle_if.sv
// Bus bundle between the RTC register-access sequencer and the bus-cycle engine.
// The engine's optional verify_err output (RTC_BUS_VERIFY_EN) is a plain module port, not part of this bundle.
interface rtc_bus_cycle_if;
    logic       start;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       bus_release;
    logic       AD;
    logic       CS;
    logic       WR;
    logic       RD;
    logic [7:0] rdata;
    logic       busy;
    logic       done;

    modport master (
        output start, rw, addr, wdata, ad_in,
        input  ad_out, bus_release, AD, CS, WR, RD, rdata, busy, done
    );

    modport slave (
        input  start, rw, addr, wdata, ad_in,
        output ad_out, bus_release, AD, CS, WR, RD, rdata, busy, done
    );
endinterface

// File: rtl/rtc_bus_cycle.sv
// Bus-cycle engine for the external RTC multiplexed AD bus: address phase then data write/read.
// Optional feature macro: RTC_BUS_VERIFY_EN (write followed by automatic readback, adds verify_err).
module rtc_bus_cycle #(
    parameter int unsigned T_SETUP  = 2,
    parameter int unsigned T_STROBE = 10,
    parameter int unsigned T_HOLD   = 2,
    parameter int unsigned T_GAP    = 2
) (
    input  logic              clk,
    input  logic              rst,
`ifdef RTC_BUS_VERIFY_EN
    output logic              verify_err,
`endif
    rtc_bus_cycle_if.slave    bus
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned T_SH   = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
    localparam int unsigned T_SG   = (T_SH > T_GAP) ? T_SH : T_GAP;
    localparam int unsigned T_MAX  = (T_SG > T_STROBE) ? T_SG : T_STROBE;
    localparam int unsigned CNT_W  = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, A_SET, A_STB, A_HLD, GAP, D_SET, D_STB, D_HLD
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rw_q, rw_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   ad_out_q, ad_out_d;
    logic                bus_release_q, bus_release_d;
    logic                ad_q, ad_d;
    logic                cs_q, cs_d;
    logic                wr_q, wr_d;
    logic                rd_q, rd_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
`ifdef RTC_BUS_VERIFY_EN
    logic                vphase_q, vphase_d;
    logic                verr_q, verr_d;
`endif

    // Dwell time of each timed state, loaded into the counter on entry.
    function automatic logic [CNT_W-1:0] dur(input state_e s);
        case (s)
            A_SET, D_SET: dur = CNT_W'(T_SETUP);
            A_STB, D_STB: dur = CNT_W'(T_STROBE);
            A_HLD, D_HLD: dur = CNT_W'(T_HOLD);
            GAP:          dur = CNT_W'(T_GAP);
            default:      dur = CNT_W'(1);
        endcase
    endfunction

    // Linear phase sequence; D_HLD's successor is decided in the FSM.
    function automatic state_e succ(input state_e s);
        case (s)
            A_SET:   succ = A_STB;
            A_STB:   succ = A_HLD;
            A_HLD:   succ = GAP;
            GAP:     succ = D_SET;
            D_SET:   succ = D_STB;
            D_STB:   succ = D_HLD;
            default: succ = IDLE;
        endcase
    endfunction

    // Next state, counter, captured request and registered strobe values.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rw_d          = rw_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        done_d        = 1'b0;
`ifdef RTC_BUS_VERIFY_EN
        vphase_d      = vphase_q;
        verr_d        = verr_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    rw_d    = bus.rw;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    state_d = A_SET;
                    cnt_d   = dur(A_SET);
                end
            end
            D_HLD: begin
                if (cnt_q == CNT_W'(1)) begin
`ifdef RTC_BUS_VERIFY_EN
                    if (!rw_q) begin
                        // Write finished: rerun the whole cycle as a read of the same address.
                        rw_d     = 1'b1;
                        vphase_d = 1'b1;
                        state_d  = A_SET;
                        cnt_d    = dur(A_SET);
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        if (vphase_q) begin
                            verr_d   = (rdata_q != wdata_q);
                            vphase_d = 1'b0;
                        end
                    end
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = succ(state_q);
                    cnt_d   = dur(succ(state_q));
                    // Sample the bus on the edge at which RD returns high.
                    if (state_q == D_STB && rw_q) begin
                        rdata_d = bus.ad_in;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase

        // Strobes are decoded from the state being entered so they register with it.
        cs_d          = 1'b1;
        ad_d          = 1'b1;
        wr_d          = 1'b1;
        rd_d          = 1'b1;
        bus_release_d = 1'b1;
        ad_out_d      = ad_out_q;
        busy_d        = (state_d != IDLE);

        case (state_d)
            A_SET, A_HLD: begin
                cs_d          = 1'b0;
                ad_d          = 1'b0;
                bus_release_d = 1'b0;
                ad_out_d      = addr_d;
            end
            A_STB: begin
                cs_d          = 1'b0;
                ad_d          = 1'b0;
                wr_d          = 1'b0;
                bus_release_d = 1'b0;
                ad_out_d      = addr_d;
            end
            GAP, D_SET, D_HLD: begin
                cs_d = 1'b0;
                if (!rw_d) begin
                    bus_release_d = 1'b0;
                    ad_out_d      = wdata_d;
                end
            end
            D_STB: begin
                cs_d = 1'b0;
                if (!rw_d) begin
                    bus_release_d = 1'b0;
                    ad_out_d      = wdata_d;
                    wr_d          = 1'b0;
                end else begin
                    rd_d = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rw_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            ad_out_q      <= '0;
            bus_release_q <= 1'b1;
            ad_q          <= 1'b1;
            cs_q          <= 1'b1;
            wr_q          <= 1'b1;
            rd_q          <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
`ifdef RTC_BUS_VERIFY_EN
            vphase_q      <= 1'b0;
            verr_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rw_q          <= rw_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            ad_out_q      <= ad_out_d;
            bus_release_q <= bus_release_d;
            ad_q          <= ad_d;
            cs_q          <= cs_d;
            wr_q          <= wr_d;
            rd_q          <= rd_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
`ifdef RTC_BUS_VERIFY_EN
            vphase_q      <= vphase_d;
            verr_q        <= verr_d;
`endif
        end
    end

    assign bus.ad_out      = ad_out_q;
    assign bus.bus_release = bus_release_q;
    assign bus.AD          = ad_q;
    assign bus.CS          = cs_q;
    assign bus.WR          = wr_q;
    assign bus.RD          = rd_q;
    assign bus.rdata       = rdata_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
`ifdef RTC_BUS_VERIFY_EN
    assign verify_err      = verr_q;
`endif

endmodule

// File: tb/tb_rtc_bus_cycle.sv
// Directed testbench for rtc_bus_cycle (default timing parameters).
module tb_rtc_bus_cycle;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef RTC_BUS_VERIFY_EN
    logic verify_err;
`endif

    rtc_bus_cycle_if bus_if ();

    rtc_bus_cycle dut (
        .clk        (clk),
        .rst        (rst),
`ifdef RTC_BUS_VERIFY_EN
        .verify_err (verify_err),
`endif
        .bus        (bus_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Per-transaction observations collected by run_txn.
    int cs_low, ad_low, wr_low, rd_low, busy_n, done_n, done_at;
    int wr_in_data, br_bad, order_bad, addr_bad, end_bad;
    logic [7:0] data_seen;

    // Start one transaction and observe ncyc cycles; optional stray start at cycle ign_at.
    task automatic run_txn(input logic rw_i, input logic [7:0] a, input logic [7:0] wd,
                           input logic [7:0] rdv, input int ign_at, input int ncyc);
        logic pcs, pwr, prd, pad;
        pcs = 1'b1; pwr = 1'b1; prd = 1'b1; pad = 1'b1;
        cs_low = 0; ad_low = 0; wr_low = 0; rd_low = 0; busy_n = 0; done_n = 0; done_at = 0;
        wr_in_data = 0; br_bad = 0; order_bad = 0; addr_bad = 0; end_bad = 0; data_seen = 8'h00;
        @(negedge clk);
        bus_if.rw    = rw_i;
        bus_if.addr  = a;
        bus_if.wdata = wd;
        bus_if.ad_in = 8'hee;
        bus_if.start = 1'b1;
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            if (!bus_if.CS) cs_low++;
            if (!bus_if.AD) ad_low++;
            if (!bus_if.WR) wr_low++;
            if (!bus_if.RD) rd_low++;
            if (bus_if.busy) busy_n++;
            if (bus_if.done) begin
                done_n++;
                if (done_at == 0) done_at = i;
                if (!(bus_if.CS && bus_if.WR && bus_if.RD && bus_if.AD && bus_if.bus_release && !bus_if.busy))
                    end_bad++;
            end
            if (!bus_if.AD && !bus_if.CS && bus_if.ad_out !== a) addr_bad++;
            if (bus_if.AD && !bus_if.CS && !bus_if.WR) begin
                wr_in_data++;
                data_seen = bus_if.ad_out;
            end
            if (rw_i && bus_if.AD && !bus_if.CS && !bus_if.bus_release) br_bad++;
            if (!pcs && bus_if.CS && (!pwr || !prd)) order_bad++;
            if (bus_if.AD !== pad && (!bus_if.WR || !bus_if.RD || !pwr || !prd)) order_bad++;
            pcs = bus_if.CS; pwr = bus_if.WR; prd = bus_if.RD; pad = bus_if.AD;
            bus_if.start = (i == ign_at);
            if (i == ign_at) begin
                bus_if.addr  = 8'h99;
                bus_if.wdata = 8'h77;
                bus_if.rw    = ~rw_i;
            end
            bus_if.ad_in = bus_if.RD ? 8'hee : rdv;
        end
        bus_if.start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus_if.AD !== 1'b1) begin bad++; $display("FAIL reset_AD got=%b want=1", bus_if.AD); end
        total++; if (bus_if.CS !== 1'b1) begin bad++; $display("FAIL reset_CS got=%b want=1", bus_if.CS); end
        total++; if (bus_if.WR !== 1'b1) begin bad++; $display("FAIL reset_WR got=%b want=1", bus_if.WR); end
        total++; if (bus_if.RD !== 1'b1) begin bad++; $display("FAIL reset_RD got=%b want=1", bus_if.RD); end
        total++; if (bus_if.bus_release !== 1'b1) begin bad++; $display("FAIL reset_release got=%b want=1", bus_if.bus_release); end
        total++; if (bus_if.ad_out !== 8'h00) begin bad++; $display("FAIL reset_ad_out got=%h want=00", bus_if.ad_out); end
        total++; if (bus_if.rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%h want=00", bus_if.rdata); end
        total++; if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus_if.busy); end
        total++; if (bus_if.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus_if.done); end
`ifdef RTC_BUS_VERIFY_EN
        total++; if (verify_err !== 1'b0) begin bad++; $display("FAIL reset_verify_err got=%b want=0", verify_err); end
`endif
    endtask

    task automatic test_write;
        run_txn(1'b0, 8'h41, 8'h21, 8'h00, 0, 36);
        total++; if (cs_low != 30) begin bad++; $display("FAIL wr_cs_low got=%0d want=30", cs_low); end
        total++; if (ad_low != 14) begin bad++; $display("FAIL wr_ad_low got=%0d want=14", ad_low); end
        total++; if (wr_low != 20) begin bad++; $display("FAIL wr_wr_low got=%0d want=20", wr_low); end
        total++; if (wr_in_data != 10) begin bad++; $display("FAIL wr_data_strobe got=%0d want=10", wr_in_data); end
        total++; if (rd_low != 0) begin bad++; $display("FAIL wr_rd_low got=%0d want=0", rd_low); end
        total++; if (busy_n != 30) begin bad++; $display("FAIL wr_busy got=%0d want=30", busy_n); end
        total++; if (done_at != 31) begin bad++; $display("FAIL wr_done_at got=%0d want=31", done_at); end
        total++; if (done_n != 1) begin bad++; $display("FAIL wr_done_count got=%0d want=1", done_n); end
        total++; if (addr_bad != 0) begin bad++; $display("FAIL wr_addr_phase got=%0d want=0", addr_bad); end
        total++; if (data_seen !== 8'h21) begin bad++; $display("FAIL wr_data got=%h want=21", data_seen); end
        total++; if (order_bad != 0) begin bad++; $display("FAIL wr_strobe_order got=%0d want=0", order_bad); end
        total++; if (end_bad != 0) begin bad++; $display("FAIL wr_end_state got=%0d want=0", end_bad); end
    endtask

    task automatic test_read;
        run_txn(1'b1, 8'h22, 8'h00, 8'h59, 0, 36);
        total++; if (bus_if.rdata !== 8'h59) begin bad++; $display("FAIL rd_rdata got=%h want=59", bus_if.rdata); end
        total++; if (rd_low != 10) begin bad++; $display("FAIL rd_rd_low got=%0d want=10", rd_low); end
        total++; if (wr_in_data != 0) begin bad++; $display("FAIL rd_wr_in_data got=%0d want=0", wr_in_data); end
        total++; if (wr_low != 10) begin bad++; $display("FAIL rd_addr_wr_low got=%0d want=10", wr_low); end
        total++; if (br_bad != 0) begin bad++; $display("FAIL rd_bus_release got=%0d want=0", br_bad); end
        total++; if (addr_bad != 0) begin bad++; $display("FAIL rd_addr_phase got=%0d want=0", addr_bad); end
        total++; if (done_at != 31) begin bad++; $display("FAIL rd_done_at got=%0d want=31", done_at); end
        total++; if (order_bad != 0) begin bad++; $display("FAIL rd_strobe_order got=%0d want=0", order_bad); end
    endtask

    task automatic test_write_keeps_rdata;
        run_txn(1'b0, 8'h05, 8'hc3, 8'h00, 0, 34);
        total++; if (bus_if.rdata !== 8'h59) begin bad++; $display("FAIL wr_keeps_rdata got=%h want=59", bus_if.rdata); end
        total++; if (data_seen !== 8'hc3) begin bad++; $display("FAIL wr2_data got=%h want=c3", data_seen); end
    endtask

    task automatic test_ignore_start;
        run_txn(1'b0, 8'h41, 8'h21, 8'h00, 5, 40);
        total++; if (done_n != 1) begin bad++; $display("FAIL ign_done_count got=%0d want=1", done_n); end
        total++; if (done_at != 31) begin bad++; $display("FAIL ign_done_at got=%0d want=31", done_at); end
        total++; if (addr_bad != 0) begin bad++; $display("FAIL ign_addr got=%0d want=0", addr_bad); end
        total++; if (data_seen !== 8'h21) begin bad++; $display("FAIL ign_data got=%h want=21", data_seen); end
        total++; if (busy_n != 30) begin bad++; $display("FAIL ign_busy got=%0d want=30", busy_n); end
    endtask

    task automatic test_reset_mid;
        int dn;
        dn = 0;
        @(negedge clk);
        bus_if.rw = 1'b0; bus_if.addr = 8'h41; bus_if.wdata = 8'h21; bus_if.start = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            bus_if.start = 1'b0;
        end
        total++; if (bus_if.WR !== 1'b0) begin bad++; $display("FAIL rstmid_in_strobe got=%b want=0", bus_if.WR); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if ({bus_if.CS, bus_if.WR, bus_if.RD, bus_if.AD} !== 4'hf) begin bad++; $display("FAIL rstmid_strobes got=%h want=f", {bus_if.CS, bus_if.WR, bus_if.RD, bus_if.AD}); end
        total++; if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", bus_if.busy); end
        total++; if (bus_if.rdata !== 8'h00) begin bad++; $display("FAIL rstmid_rdata got=%h want=00", bus_if.rdata); end
        total++; if (bus_if.bus_release !== 1'b1) begin bad++; $display("FAIL rstmid_release got=%b want=1", bus_if.bus_release); end
        for (int i = 0; i < 35; i++) begin
            if (bus_if.done) dn++;
            @(negedge clk);
        end
        total++; if (dn != 0) begin bad++; $display("FAIL rstmid_no_done got=%0d want=0", dn); end
    endtask

    task automatic test_back_to_back;
        int d1, d2, cs_hi, busy32;
        d1 = 0; d2 = 0; cs_hi = 0; busy32 = 0;
        @(negedge clk);
        bus_if.rw = 1'b0; bus_if.addr = 8'h30; bus_if.wdata = 8'h31; bus_if.start = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (bus_if.done) begin
                if (d1 == 0) d1 = i;
                else if (d2 == 0) d2 = i;
            end
            if (i <= 61 && bus_if.CS) cs_hi++;
            if (i == 32) busy32 = bus_if.busy;
            if (i == 32) bus_if.start = 1'b0;
        end
        total++; if (d1 != 31) begin bad++; $display("FAIL b2b_done1 got=%0d want=31", d1); end
        total++; if (d2 != 62) begin bad++; $display("FAIL b2b_done2 got=%0d want=62", d2); end
        total++; if (cs_hi != 1) begin bad++; $display("FAIL b2b_idle_gap got=%0d want=1", cs_hi); end
        total++; if (busy32 != 1) begin bad++; $display("FAIL b2b_second_busy got=%0d want=1", busy32); end
    endtask

`ifdef RTC_BUS_VERIFY_EN
    task automatic test_verify;
        run_txn(1'b0, 8'h12, 8'h12, 8'h13, 0, 64);
        total++; if (busy_n != 60) begin bad++; $display("FAIL vfy_busy got=%0d want=60", busy_n); end
        total++; if (done_at != 61) begin bad++; $display("FAIL vfy_done_at got=%0d want=61", done_at); end
        total++; if (verify_err !== 1'b1) begin bad++; $display("FAIL vfy_err_set got=%b want=1", verify_err); end
        total++; if (bus_if.rdata !== 8'h13) begin bad++; $display("FAIL vfy_rdata got=%h want=13", bus_if.rdata); end
        run_txn(1'b0, 8'h12, 8'h12, 8'h12, 0, 64);
        total++; if (verify_err !== 1'b0) begin bad++; $display("FAIL vfy_err_clr got=%b want=0", verify_err); end
        total++; if (done_n != 1) begin bad++; $display("FAIL vfy_done_count got=%0d want=1", done_n); end
    endtask
`endif

    initial begin
        bus_if.start = 1'b0;
        bus_if.rw    = 1'b0;
        bus_if.addr  = 8'h00;
        bus_if.wdata = 8'h00;
        bus_if.ad_in = 8'hee;
        test_reset();
`ifdef RTC_BUS_VERIFY_EN
        test_read();
        test_verify();
`else
        test_write();
        test_read();
        test_write_keeps_rdata();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
